// File: rtl/elevator_scheduler.sv
// elevator_scheduler: four-floor SCAN elevator controller with latched calls and tick-paced travel/door timing.
// Optional emergency stop (estop port, HALT state) is enabled by defining ELEV_ESTOP_EN.
module elevator_scheduler #(
    parameter int MOVE_TICKS = 2,
    parameter int DOOR_TICKS = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic [3:0] call_req,
`ifdef ELEV_ESTOP_EN
    input  logic       estop,
`endif
    output logic [1:0] curr_floor,
    output logic [3:0] pending,
    output logic       dir_up,
    output logic       moving,
    output logic       door_open
);
    localparam int MW = MOVE_TICKS > 1 ? $clog2(MOVE_TICKS) : 1;
    localparam int DW = DOOR_TICKS > 1 ? $clog2(DOOR_TICKS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        MOVE,
        DOOR
`ifdef ELEV_ESTOP_EN
        , HALT
`endif
    } state_t;

    state_t        state;
    logic [MW-1:0] move_cnt;
    logic [DW-1:0] door_cnt;
    logic [3:0]    here;
    logic [3:0]    next_mask;
    logic [1:0]    next_floor;
    logic [3:0]    above;
    logic [3:0]    below;
    logic [3:0]    ahead;
    logic [3:0]    new_calls;
    logic          go_up;

    // SCAN helpers: floor masks, calls above/below the car, calls beyond the next floor, and calls to latch
    always_comb begin
        here       = 4'b0001 << curr_floor;
        next_floor = dir_up ? (curr_floor == 2'd3 ? 2'd3 : curr_floor + 2'd1)
                            : (curr_floor == 2'd0 ? 2'd0 : curr_floor - 2'd1);
        next_mask  = 4'b0001 << next_floor;
        above      = '0;
        below      = '0;
        ahead      = '0;
        for (int i = 0; i < 4; i++) begin
            above[i] = pending[i] && (i > int'(curr_floor));
            below[i] = pending[i] && (i < int'(curr_floor));
            ahead[i] = pending[i] && (dir_up ? (i > int'(next_floor)) : (i < int'(next_floor)));
        end
        go_up     = dir_up ? |above : ~|below;
        new_calls = (state == DOOR) ? (call_req & ~here) : call_req;
    end

    // Controller FSM: call latching every clk, state and counters advance on tick
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            curr_floor <= 2'd0;
            pending    <= 4'b0000;
            dir_up     <= 1'b1;
            moving     <= 1'b0;
            door_open  <= 1'b0;
            move_cnt   <= '0;
            door_cnt   <= '0;
        end
`ifdef ELEV_ESTOP_EN
        else if (estop) begin
            state     <= HALT;
            moving    <= 1'b0;
            door_open <= 1'b0;
            pending   <= pending | call_req;
        end else if (state == HALT) begin
            state    <= IDLE;
            move_cnt <= '0;
            door_cnt <= '0;
            pending  <= pending | call_req;
        end
`endif
        else begin
            pending <= pending | new_calls;
            if (state == DOOR && |(call_req & here)) begin
                door_cnt <= '0;
            end else if (tick) begin
                case (state)
                    IDLE: begin
                        if (|(pending & here)) begin
                            state     <= DOOR;
                            door_open <= 1'b1;
                            door_cnt  <= '0;
                            pending   <= (pending | new_calls) & ~here;
                        end else if (|pending) begin
                            dir_up   <= go_up;
                            state    <= MOVE;
                            moving   <= 1'b1;
                            move_cnt <= '0;
                        end
                    end
                    MOVE: begin
                        if (move_cnt == MW'(MOVE_TICKS - 1)) begin
                            move_cnt   <= '0;
                            curr_floor <= next_floor;
                            if (|(pending & next_mask)) begin
                                state     <= DOOR;
                                moving    <= 1'b0;
                                door_open <= 1'b1;
                                door_cnt  <= '0;
                                pending   <= (pending | new_calls) & ~next_mask;
                            end else if (!(|ahead)) begin
                                state  <= IDLE;
                                moving <= 1'b0;
                            end
                        end else begin
                            move_cnt <= move_cnt + 1'b1;
                        end
                    end
                    DOOR: begin
                        if (door_cnt == DW'(DOOR_TICKS - 1)) begin
                            state     <= IDLE;
                            door_open <= 1'b0;
                            door_cnt  <= '0;
                        end else begin
                            door_cnt <= door_cnt + 1'b1;
                        end
                    end
                    default: begin
                        state     <= IDLE;
                        moving    <= 1'b0;
                        door_open <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler: vector table with a scoreboard queue plus hand-written multi-cycle sequences.
module tb_elevator_scheduler;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       tick = 1'b1;
    logic [3:0] call_req = 4'b0000;
    logic       estop = 1'b0;
    logic [1:0] curr_floor;
    logic [3:0] pending;
    logic       dir_up;
    logic       moving;
    logic       door_open;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic       rst;
        logic       tck;
        logic [3:0] call;
        logic [8:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] sb[$];

    elevator_scheduler #(.MOVE_TICKS(2), .DOOR_TICKS(3)) dut (
        .clk(clk),
        .reset(reset),
        .tick(tick),
        .call_req(call_req),
`ifdef ELEV_ESTOP_EN
        .estop(estop),
`endif
        .curr_floor(curr_floor),
        .pending(pending),
        .dir_up(dir_up),
        .moving(moving),
        .door_open(door_open)
    );

    always #5 clk = ~clk;

    task automatic add(input logic r, input logic t, input logic [3:0] c,
                       input logic [1:0] f, input logic [3:0] p, input logic u, input logic m, input logic d);
        vecs.push_back('{r, t, c, {f, p, u, m, d}});
    endtask

    task automatic step(input logic r, input logic t, input logic [3:0] c);
        reset = r;
        tick = t;
        call_req = c;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [8:0] got, input logic [8:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    initial begin
        logic [8:0] e;
        // reset, then call to floor 2: move, step, stop; door restarted by a call at floor 2
        add(1,1,4'b0000, 0,4'b0000,1,0,0);
        add(0,1,4'b0100, 0,4'b0100,1,0,0);
        add(0,1,4'b0000, 0,4'b0100,1,1,0);
        add(0,1,4'b0000, 0,4'b0100,1,1,0);
        add(0,1,4'b0000, 1,4'b0100,1,1,0);
        add(0,1,4'b0000, 1,4'b0100,1,1,0);
        add(0,1,4'b0000, 2,4'b0000,1,0,1);
        add(0,1,4'b0100, 2,4'b0000,1,0,1);
        add(0,1,4'b0000, 2,4'b0000,1,0,1);
        add(0,1,4'b0000, 2,4'b0000,1,0,1);
        add(0,1,4'b0000, 2,4'b0000,1,0,0);
        // calls at 3 and 0: serve 3 first, then reverse down to 0
        add(0,1,4'b1001, 2,4'b1001,1,0,0);
        add(0,1,4'b0000, 2,4'b1001,1,1,0);
        add(0,1,4'b0000, 2,4'b1001,1,1,0);
        add(0,1,4'b0000, 3,4'b0001,1,0,1);
        add(0,1,4'b0000, 3,4'b0001,1,0,1);
        add(0,1,4'b0000, 3,4'b0001,1,0,1);
        add(0,1,4'b0000, 3,4'b0001,1,0,0);
        add(0,1,4'b0000, 3,4'b0001,0,1,0);
        add(0,1,4'b0000, 3,4'b0001,0,1,0);
        add(0,1,4'b0000, 2,4'b0001,0,1,0);
        add(0,1,4'b0000, 2,4'b0001,0,1,0);
        add(0,1,4'b0000, 1,4'b0001,0,1,0);
        add(0,1,4'b0000, 1,4'b0001,0,1,0);
        add(0,1,4'b0000, 0,4'b0000,0,0,1);
        add(0,1,4'b0000, 0,4'b0000,0,0,1);
        add(0,1,4'b0000, 0,4'b0000,0,0,1);
        add(0,1,4'b0000, 0,4'b0000,0,0,0);
        // call at the current floor: door for exactly three ticks
        add(0,1,4'b0001, 0,4'b0001,0,0,0);
        add(0,1,4'b0000, 0,4'b0000,0,0,1);
        add(0,1,4'b0000, 0,4'b0000,0,0,1);
        add(0,1,4'b0000, 0,4'b0000,0,0,1);
        add(0,1,4'b0000, 0,4'b0000,0,0,0);
        add(0,1,4'b0000, 0,4'b0000,0,0,0);
        // reverse from down to up, then reset mid-move
        add(0,1,4'b0100, 0,4'b0100,0,0,0);
        add(0,1,4'b0000, 0,4'b0100,1,1,0);
        add(0,1,4'b0000, 0,4'b0100,1,1,0);
        add(0,1,4'b0000, 1,4'b0100,1,1,0);
        add(1,1,4'b0000, 0,4'b0000,1,0,0);
        // calls latch without tick; FSM only advances on tick
        add(0,0,4'b1000, 0,4'b1000,1,0,0);
        add(0,0,4'b0000, 0,4'b1000,1,0,0);
        add(0,1,4'b0000, 0,4'b1000,1,1,0);
        add(0,0,4'b0000, 0,4'b1000,1,1,0);
        add(0,1,4'b0000, 0,4'b1000,1,1,0);
        add(0,1,4'b0000, 1,4'b1000,1,1,0);
        // reset beats calls
        add(1,1,4'b1111, 0,4'b0000,1,0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            sb.push_back(vecs[i].exp);
            step(vecs[i].rst, vecs[i].tck, vecs[i].call);
            e = sb.pop_front();
            chk($sformatf("vec%0d", i), {curr_floor, pending, dir_up, moving, door_open}, e);
        end

        // full trip from floor 0 to floor 3 with a bounded wait
        step(0, 1, 4'b1000);
        for (int k = 0; k < 40 && !door_open; k++) step(0, 1, 4'b0000);
        chk("trip3_door", 9'(door_open), 9'd1);
        chk("trip3_floor", 9'(curr_floor), 9'd3);
        chk("trip3_pending", 9'(pending), 9'd0);

`ifdef ELEV_ESTOP_EN
        step(1, 1, 4'b0000);
        step(0, 1, 4'b0100);
        step(0, 1, 4'b0000);
        chk("estop_pre_move", 9'(moving), 9'd1);
        estop = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 4'b0000);
            chk($sformatf("estop_hold%0d", k), {7'(curr_floor), moving, door_open}, 9'd0);
        end
        estop = 1'b0;
        step(0, 1, 4'b0000);
        chk("estop_release_idle", {7'(curr_floor), moving, door_open}, 9'd0);
        for (int k = 0; k < 40 && !door_open; k++) step(0, 1, 4'b0000);
        chk("estop_resume_floor", 9'(curr_floor), 9'd2);
        chk("estop_resume_pending", 9'(pending), 9'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
